// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: one bus transaction at a time, load alignment/extension, store lane masks.
// Latency: 1 cycle for ALU pass-through, 3+ cycles for memory ops; holds each output until its ready.
module ysyx_25040105_lsu #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [1:0]  out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;

  localparam logic [1:0]  ERR_OK   = 2'b00;
  localparam logic [1:0]  ERR_MIS  = 2'b01;
  localparam logic [1:0]  ERR_TO   = 2'b10;
  localparam logic [15:0] CNT_LAST = 16'(RESP_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        wr_q, wr_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_wen_q, rd_wen_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_wen_q, req_wen_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wmask_q, req_wmask_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_rd_wen_q, out_rd_wen_d;
  logic [1:0]  out_err_q, out_err_d;

  logic        in_mem, in_mis;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [31:0] load_v, load_ext;

  assign in_mem = in_mem_ren | in_mem_wen;
  assign in_mis = ((in_size == 2'b01) && in_addr[0]) || (in_size[1] && (in_addr[1:0] != 2'b00));

  always_comb begin
    st_wdata = in_wdata;
    st_wmask = 4'b1111;
    case (in_size)
      2'b00: begin
        st_wdata = {4{in_wdata[7:0]}};
        st_wmask = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_wdata[15:0]}};
        st_wmask = 4'b0011 << in_addr[1:0];
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by the latched size.
  assign load_v = mem_resp_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = load_v;
    if (size_q == 2'b00) begin
      load_ext = uns_q ? {24'b0, load_v[7:0]} : {{24{load_v[7]}}, load_v[7:0]};
    end else if (size_q == 2'b01) begin
      load_ext = uns_q ? {16'b0, load_v[15:0]} : {{16{load_v[15]}}, load_v[15:0]};
    end
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    rd_wen_d     = rd_wen_q;
    cnt_d        = cnt_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_wen_d    = req_wen_q;
    req_wdata_d  = req_wdata_q;
    req_wmask_d  = req_wmask_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rd_d     = out_rd_q;
    out_rd_wen_d = out_rd_wen_q;
    out_err_d    = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          size_d   = in_size;
          uns_d    = in_unsigned;
          off_d    = in_addr[1:0];
          wr_d     = in_mem_wen;
          rd_d     = in_rd;
          rd_wen_d = in_rd_wen;
          if (!in_mem) begin
            state_d      = OUT;
            out_valid_d  = 1'b1;
            out_data_d   = in_alu_result;
            out_rd_d     = in_rd;
            out_rd_wen_d = in_rd_wen;
            out_err_d    = ERR_OK;
          end else if (in_mis) begin
            state_d      = OUT;
            out_valid_d  = 1'b1;
            out_data_d   = 32'h0;
            out_rd_d     = in_rd;
            out_rd_wen_d = 1'b0;
            out_err_d    = ERR_MIS;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_addr_d  = {in_addr[31:2], 2'b00};
            req_wen_d   = in_mem_wen;
            req_wdata_d = st_wdata;
            req_wmask_d = in_mem_wen ? st_wmask : 4'b0000;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d     = WAIT;
          cnt_d       = 16'd0;
          req_valid_d = 1'b0;
          req_addr_d  = 32'h0;
          req_wen_d   = 1'b0;
          req_wdata_d = 32'h0;
          req_wmask_d = 4'b0000;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d      = OUT;
          out_valid_d  = 1'b1;
          out_data_d   = wr_q ? 32'h0 : load_ext;
          out_rd_d     = rd_q;
          out_rd_wen_d = rd_wen_q;
          out_err_d    = ERR_OK;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = OUT;
          out_valid_d  = 1'b1;
          out_data_d   = 32'h0;
          out_rd_d     = rd_q;
          out_rd_wen_d = 1'b0;
          out_err_d    = ERR_TO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d      = IDLE;
          out_valid_d  = 1'b0;
          out_data_d   = 32'h0;
          out_rd_d     = 5'd0;
          out_rd_wen_d = 1'b0;
          out_err_d    = ERR_OK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wr_q         <= 1'b0;
      rd_q         <= 5'd0;
      rd_wen_q     <= 1'b0;
      cnt_q        <= 16'd0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= 32'h0;
      req_wen_q    <= 1'b0;
      req_wdata_q  <= 32'h0;
      req_wmask_q  <= 4'b0000;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      out_rd_q     <= 5'd0;
      out_rd_wen_q <= 1'b0;
      out_err_q    <= ERR_OK;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      rd_wen_q     <= rd_wen_d;
      cnt_q        <= cnt_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_wen_q    <= req_wen_d;
      req_wdata_q  <= req_wdata_d;
      req_wmask_q  <= req_wmask_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_q     <= out_rd_d;
      out_rd_wen_q <= out_rd_wen_d;
      out_err_q    <= out_err_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_rd        = out_rd_q;
  assign out_rd_wen    = out_rd_wen_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Bench for ysyx_25040105_lsu: directed cases from the test plan, then randomized ops against a byte-level model.
module tb_ysyx_25040105_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_mem_ren, in_mem_wen, in_unsigned, in_rd_wen;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_alu_result;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_rd_wen;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25040105_lsu #(.RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_err(out_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one instruction end to end; the expected bus and write-back values come from
  // byte-lane arithmetic over the access, not from the design's encoding.
  task automatic run_op(input logic ren, input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [4:0] rd, input logic rdwen,
                        input int stall, input int lat, input int hold, input string tag,
                        output logic [31:0] o_wdata, output logic [3:0] o_wmask,
                        output logic [31:0] o_data, output logic [1:0] o_err);
    int n, off;
    logic mem, mis, e_rdwen;
    logic [31:0] e_data, e_wdata, v;
    logic [3:0] e_wmask;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    mem = ren | wen;
    mis = mem && ((off % n) != 0);
    e_wmask = 4'b0000;
    e_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (wen && i >= off && i < off + n) e_wmask[i] = 1'b1;
      e_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    v = 32'h0;
    for (int i = 0; i < n && off + i < 4; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    e_data  = !mem ? alu : (wen ? 32'h0 : v);
    e_rdwen = mis ? 1'b0 : rdwen;

    in_valid = 1'b1; in_mem_ren = ren; in_mem_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wd; in_alu_result = alu; in_rd = rd; in_rd_wen = rdwen;
    step();
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_alu_result = $urandom;
    if (mem && !mis) begin
      chk({tag, ".req_valid"}, mem_req_valid, 1);
      chk({tag, ".req_addr"}, mem_req_addr, {addr[31:2], 2'b00});
      chk({tag, ".req_wen"}, mem_req_wen, wen);
      chk({tag, ".req_wmask"}, mem_req_wmask, e_wmask);
      if (wen) chk({tag, ".req_wdata"}, mem_req_wdata, e_wdata);
      o_wdata = mem_req_wdata;
      o_wmask = mem_req_wmask;
      for (int s = 0; s < stall; s++) begin
        step();
        chk({tag, ".stall_valid"}, mem_req_valid, 1);
        chk({tag, ".stall_addr"}, mem_req_addr, {addr[31:2], 2'b00});
        chk({tag, ".stall_wdata"}, mem_req_wdata, o_wdata);
        chk({tag, ".stall_wmask"}, mem_req_wmask, o_wmask);
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk({tag, ".req_drop"}, mem_req_valid, 0);
      for (int l = 0; l < lat; l++) begin
        chk({tag, ".wait_out"}, out_valid, 0);
        step();
      end
      mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
      step();
      mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
    end else begin
      chk({tag, ".no_req"}, mem_req_valid, 0);
      o_wdata = 32'h0;
      o_wmask = 4'b0000;
    end
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".out_err"}, out_err, mis ? 2'b01 : 2'b00);
    chk({tag, ".out_rd"}, out_rd, rd);
    chk({tag, ".out_rd_wen"}, out_rd_wen, e_rdwen);
    if (!mis) chk({tag, ".out_data"}, out_data, e_data);
    o_data = out_data;
    o_err  = out_err;
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_data"}, out_data, o_data);
      chk({tag, ".hold_rd"}, out_rd, rd);
      chk({tag, ".hold_err"}, out_err, o_err);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".idle_out"}, out_valid, 0);
    chk({tag, ".idle_rdy"}, in_ready, 1);
  endtask

  logic [31:0] w, d;
  logic [3:0]  m;
  logic [1:0]  e;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_mem_ren = 0; in_mem_wen = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; in_alu_result = 0; in_rd = 0; in_rd_wen = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 0;
    step();
    chk("rst.in_ready", in_ready, 1);
    chk("rst.req_valid", mem_req_valid, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_err", out_err, 0);
    step();
    rst_n = 1'b1;
    step();

    run_op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 5'd5, 1, 0, 0, 3, "alu", w, m, d, e);
    chk("alu.data", d, 32'h1234_5678);
    run_op(1, 0, 2'b00, 0, 32'h8000_0003, 32'h0, 32'h0, 32'h80AB_CDEF, 5'd7, 1, 0, 0, 0, "lb", w, m, d, e);
    chk("lb.data", d, 32'hFFFF_FF80);
    chk("lb.wmask", m, 4'b0000);
    run_op(1, 0, 2'b00, 1, 32'h8000_0003, 32'h0, 32'h0, 32'h8012_3456, 5'd7, 1, 0, 1, 0, "lbu", w, m, d, e);
    chk("lbu.data", d, 32'h0000_0080);
    run_op(0, 1, 2'b01, 0, 32'h8000_0002, 32'hAAAA_BEEF, 32'h0, 32'h0, 5'd0, 0, 2, 0, 0, "sh", w, m, d, e);
    chk("sh.wdata", w, 32'hBEEF_BEEF);
    chk("sh.wmask", m, 4'b1100);
    run_op(1, 0, 2'b10, 0, 32'h8000_0006, 32'h0, 32'h0, 32'h0, 5'd9, 1, 0, 0, 0, "lw_mis", w, m, d, e);
    chk("lw_mis.err", e, 2'b01);

    // Timeout with no response, then stray responses in OUT and IDLE.
    in_valid = 1; in_mem_ren = 1; in_mem_wen = 0; in_size = 2'b10; in_addr = 32'h8000_0020;
    in_rd = 5'd3; in_rd_wen = 1;
    step();
    in_valid = 0;
    chk("to.req_valid", mem_req_valid, 1);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("to.early_out", out_valid, 0);
    end
    step();
    chk("to.out_valid", out_valid, 1);
    chk("to.out_err", out_err, 2'b10);
    chk("to.rd_wen", out_rd_wen, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
    step();
    chk("to.late_err", out_err, 2'b10);
    chk("to.late_valid", out_valid, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("to.idle_out", out_valid, 0);
    step();
    chk("to.idle_ignore", out_valid, 0);
    chk("to.idle_req", mem_req_valid, 0);
    chk("to.idle_rdy", in_ready, 1);
    mem_resp_valid = 0;

    // Reset pulses while in REQ and while in WAIT.
    in_valid = 1; in_mem_ren = 1; in_mem_wen = 0; in_size = 2'b10; in_addr = 32'h8000_0040;
    step();
    in_valid = 0;
    chk("rq.req_valid", mem_req_valid, 1);
    rst_n = 0;
    #1;
    chk("rq.req_drop", mem_req_valid, 0);
    chk("rq.in_ready", in_ready, 1);
    step();
    rst_n = 1;
    step();
    in_valid = 1;
    step();
    in_valid = 0;
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    step();
    rst_n = 0;
    #1;
    chk("rw.req_valid", mem_req_valid, 0);
    chk("rw.out_valid", out_valid, 0);
    chk("rw.in_ready", in_ready, 1);
    step();
    rst_n = 1;
    mem_resp_valid = 1;
    step();
    mem_resp_valid = 0;
    chk("rw.after_out", out_valid, 0);
    chk("rw.after_rdy", in_ready, 1);
    run_op(0, 1, 2'b10, 0, 32'h8000_0010, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, "sw", w, m, d, e);
    chk("sw.wmask", m, 4'b1111);
    chk("sw.wdata", w, 32'h0BAD_F00D);

    for (int k = 0; k < 40; k++) begin
      run_op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), "rnd", w, m, d, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
